// File: rtl/kitchen_timer_pkg.sv
// Shared types and constants for the kitchen timer controller and its BCD counters.
package kitchen_timer_pkg;

  typedef enum logic [1:0] {
    StSet   = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StAlarm = 2'b11
  } state_e;

  localparam logic [7:0] BCD_ZERO    = 8'h00;
  localparam logic [7:0] SEC_MAX_BCD = 8'h59;
  localparam logic [7:0] MIN_MAX_BCD = 8'h99;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Two-digit BCD encoding of a small binary constant (0..99).
  function automatic logic [7:0] to_bcd(input int unsigned val);
    return {4'(val / 10), 4'(val % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter that wraps between 00 and MaxVal.
module bcd_mod_counter
  import kitchen_timer_pkg::*;
#(
  parameter int unsigned MaxVal = 59
) (
  input  logic       CLK,
  input  logic       RES_X,
  input  logic       clear_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       wrap_i,
  output logic [7:0] value_o,
  output logic       carry_o,
  output logic       borrow_o
);

  localparam logic [7:0] MaxBcd = to_bcd(MaxVal);

  logic [7:0] value_q, value_d;
  logic [3:0] tens, ones;

  assign tens     = value_q[7:4];
  assign ones     = value_q[3:0];
  assign value_o  = value_q;
  assign carry_o  = inc_i & (value_q == MaxBcd);
  assign borrow_o = dec_i & (value_q == BCD_ZERO);

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = BCD_ZERO;
    end else if (inc_i) begin
      if (value_q == MaxBcd) begin
        value_d = wrap_i ? BCD_ZERO : value_q;
      end else if (ones == 4'd9) begin
        value_d = {tens + 4'd1, 4'd0};
      end else begin
        value_d = {tens, ones + 4'd1};
      end
    end else if (dec_i) begin
      if (value_q == BCD_ZERO) begin
        value_d = wrap_i ? MaxBcd : value_q;
      end else if (ones == 4'd0) begin
        value_d = {tens - 4'd1, 4'd9};
      end else begin
        value_d = {tens, ones - 4'd1};
      end
    end
  end

  always_ff @(posedge CLK or negedge RES_X) begin
    if (!RES_X) begin
      value_q <= BCD_ZERO;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// Kitchen timer SET/RUN/PAUSE/ALARM sequencer owning the mm:ss BCD registers.
// Define KITCHEN_TIMER_ALARM_TIMEOUT_EN to end ALARM automatically after ALARM_SECS ticks.
module kitchen_timer_ctrl
  import kitchen_timer_pkg::*;
#(
  parameter int unsigned MAX_MIN = 99,
  parameter int unsigned MAX_SEC = 59
`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
  ,
  parameter int unsigned ALARM_SECS = 10
`endif
) (
  input  logic       CLK,
  input  logic       RES_X,
  input  logic       ONE_SEC_PULSE,
  input  logic       HALF_SEC_PULSE,
  input  logic       DEBOUNCED_M_INPUT,
  input  logic       DEBOUNCED_S_INPUT,
  input  logic       DEBOUNCED_START,
  input  logic       DEBOUNCED_STOP,
  input  logic       DEBOUNCED_UP_DOWN,
  output logic [7:0] MIN_BCD,
  output logic [7:0] SEC_BCD,
  output logic       RUNNING,
  output logic       COLON_ON,
  output logic       BUZZER
);

  localparam logic [7:0] MinMaxBcd    = to_bcd(MAX_MIN);
  localparam logic [7:0] SecPreMaxBcd = to_bcd(MAX_SEC - 1);
  localparam logic [7:0] SecOneBcd    = to_bcd(1);

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic       blink_q, blink_d;
  logic [7:0] min_bcd, sec_bcd;
  logic       sec_inc, sec_dec, sec_clr;
  logic       min_inc_edit, min_inc, min_dec, min_clr;
  logic       sec_carry, sec_borrow, min_carry, min_borrow;
  logic       time_zero, any_button, alarm_entry;
  logic       alarm_timeout;
  logic       unused_min_flags;

  assign time_zero  = (min_bcd == BCD_ZERO) && (sec_bcd == BCD_ZERO);
  assign any_button = DEBOUNCED_START | DEBOUNCED_STOP | DEBOUNCED_M_INPUT | DEBOUNCED_S_INPUT;

  // Minutes only follow second carries/borrows while counting, never during edits.
  assign min_inc = min_inc_edit | (sec_carry & (state_q == StRun));
  assign min_dec = sec_borrow & (state_q == StRun);
  // Minute wrap is a legal up-count rollover and underflow cannot occur.
  assign unused_min_flags = min_carry ^ min_borrow;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    sec_inc      = 1'b0;
    sec_dec      = 1'b0;
    sec_clr      = 1'b0;
    min_inc_edit = 1'b0;
    min_clr      = 1'b0;
    case (state_q)
      StSet: begin
        if (DEBOUNCED_STOP) begin
          min_clr = 1'b1;
          sec_clr = 1'b1;
        end else begin
          min_inc_edit = DEBOUNCED_M_INPUT;
          sec_inc      = DEBOUNCED_S_INPUT;
          if (DEBOUNCED_START) begin
            dir_d = DEBOUNCED_UP_DOWN;
            if (DEBOUNCED_UP_DOWN == DIR_UP || !time_zero) begin
              state_d = StRun;
            end
          end
        end
      end
      StRun: begin
        if (DEBOUNCED_STOP) begin
          state_d = StPause;
        end else if (ONE_SEC_PULSE) begin
          if (dir_q == DIR_UP) begin
            sec_inc = 1'b1;
            if (min_bcd == MinMaxBcd && sec_bcd == SecPreMaxBcd) begin
              state_d = StAlarm;
            end
          end else begin
            sec_dec = 1'b1;
            if (min_bcd == BCD_ZERO && sec_bcd == SecOneBcd) begin
              state_d = StAlarm;
            end
          end
        end
      end
      StPause: begin
        if (DEBOUNCED_STOP) begin
          min_clr = 1'b1;
          sec_clr = 1'b1;
          state_d = StSet;
        end else begin
          min_inc_edit = DEBOUNCED_M_INPUT;
          sec_inc      = DEBOUNCED_S_INPUT;
          if (DEBOUNCED_START) begin
            state_d = (dir_q == DIR_DOWN && time_zero) ? StSet : StRun;
          end
        end
      end
      StAlarm: begin
        if (any_button || alarm_timeout) begin
          min_clr = 1'b1;
          sec_clr = 1'b1;
          state_d = StSet;
        end
      end
      default: state_d = StSet;
    endcase
  end

  assign alarm_entry = (state_d == StAlarm) && (state_q != StAlarm);

  always_comb begin
    blink_d = HALF_SEC_PULSE ? ~blink_q : blink_q;
    if (alarm_entry) begin
      blink_d = 1'b1;
    end
  end

`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
  localparam int unsigned AlarmCntW = $clog2(ALARM_SECS + 1);
  localparam logic [AlarmCntW-1:0] AlarmCntLast = AlarmCntW'(ALARM_SECS - 1);

  logic [AlarmCntW-1:0] alarm_cnt_q, alarm_cnt_d;

  assign alarm_timeout = (state_q == StAlarm) && ONE_SEC_PULSE && (alarm_cnt_q == AlarmCntLast);

  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if (alarm_entry) begin
      alarm_cnt_d = '0;
    end else if (state_q == StAlarm && ONE_SEC_PULSE) begin
      alarm_cnt_d = alarm_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RES_X) begin
    if (!RES_X) begin
      alarm_cnt_q <= '0;
    end else begin
      alarm_cnt_q <= alarm_cnt_d;
    end
  end
`else
  assign alarm_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RES_X) begin
    if (!RES_X) begin
      state_q <= StSet;
      dir_q   <= DIR_DOWN;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      blink_q <= blink_d;
    end
  end

  bcd_mod_counter #(
    .MaxVal(MAX_SEC)
  ) u_sec_cnt (
    .CLK     (CLK),
    .RES_X   (RES_X),
    .clear_i (sec_clr),
    .inc_i   (sec_inc),
    .dec_i   (sec_dec),
    .wrap_i  (1'b1),
    .value_o (sec_bcd),
    .carry_o (sec_carry),
    .borrow_o(sec_borrow)
  );

  bcd_mod_counter #(
    .MaxVal(MAX_MIN)
  ) u_min_cnt (
    .CLK     (CLK),
    .RES_X   (RES_X),
    .clear_i (min_clr),
    .inc_i   (min_inc),
    .dec_i   (min_dec),
    .wrap_i  (1'b1),
    .value_o (min_bcd),
    .carry_o (min_carry),
    .borrow_o(min_borrow)
  );

  assign MIN_BCD  = min_bcd;
  assign SEC_BCD  = sec_bcd;
  assign RUNNING  = (state_q == StRun);
  assign COLON_ON = (state_q == StRun) ? blink_q : 1'b1;
  assign BUZZER   = (state_q == StAlarm) & blink_q;

endmodule
